// File: rtl/axis_frame_arbiter_if.sv
// Bundle of PORTS AXI-stream inputs and the single merged AXI-stream output.
// Handshake: a beat transfers on a rising clk edge where tvalid and tready are both 1; a source holds its beat until accepted.
interface axis_frame_arbiter_if #(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 8
);
   logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata;
   logic [PORTS-1:0]            input_axis_tvalid;
   logic [PORTS-1:0]            input_axis_tready;
   logic [PORTS-1:0]            input_axis_tlast;
   logic [PORTS-1:0]            input_axis_tuser;
   logic [DATA_WIDTH-1:0]       output_axis_tdata;
   logic                        output_axis_tvalid;
   logic                        output_axis_tready;
   logic                        output_axis_tlast;
   logic                        output_axis_tuser;

   // Sources and sink side (stimulus / surrounding fabric).
   modport master (
      output input_axis_tdata, input_axis_tvalid, input_axis_tlast, input_axis_tuser,
      output output_axis_tready,
      input  input_axis_tready,
      input  output_axis_tdata, output_axis_tvalid, output_axis_tlast, output_axis_tuser
   );

   // Arbiter side.
   modport slave (
      input  input_axis_tdata, input_axis_tvalid, input_axis_tlast, input_axis_tuser,
      input  output_axis_tready,
      output input_axis_tready,
      output output_axis_tdata, output_axis_tvalid, output_axis_tlast, output_axis_tuser
   );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter: merges PORTS AXI streams into one registered
// output stream, holding each grant from the first beat through the tlast beat.
module axis_frame_arbiter #(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_WIDTH  = $clog2(PORTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   axis_frame_arbiter_if.slave  bus,
   output logic                 grant_valid,
   output logic [IDX_WIDTH-1:0] grant_index
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                state, state_next;
   logic [IDX_WIDTH-1:0]  grant_q, grant_next;
   logic [IDX_WIDTH-1:0]  last_grant, last_grant_next;
   logic [IDX_WIDTH-1:0]  arb_sel;
   logic                  arb_hit;
   logic [DATA_WIDTH-1:0] out_data, out_data_next;
   logic                  out_valid, out_valid_next;
   logic                  out_last, out_last_next;
   logic                  out_user, out_user_next;
   logic                  load;
   logic                  accept;
   logic [PORTS-1:0]      ready;

   // Round-robin scan starting just above the last served port, wrapping at PORTS-1.
   always_comb begin
      int idx;
      logic [IDX_WIDTH-1:0] cand;
      arb_sel = '0;
      arb_hit = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int i = 1; i <= PORTS; i++) begin
         idx  = (32'(last_grant) + i) % PORTS;
         cand = idx[IDX_WIDTH-1:0];
         if (!arb_hit && bus.input_axis_tvalid[cand]) begin
            arb_sel = cand;
            arb_hit = 1'b1;
         end
      end
   end

   // The output register can take a new beat when it is empty or being drained.
   assign load   = bus.output_axis_tready | ~out_valid;
   assign accept = (state == BUSY) & bus.input_axis_tvalid[grant_q] & load;

   always_comb begin
      ready = '0;
      if (state == BUSY) begin
         ready[grant_q] = load;
      end
   end

   always_comb begin
      state_next      = state;
      grant_next      = grant_q;
      last_grant_next = last_grant;
      out_data_next   = out_data;
      out_valid_next  = out_valid;
      out_last_next   = out_last;
      out_user_next   = out_user;

      if (load) begin
         out_valid_next = accept;
         if (accept) begin
            out_data_next = bus.input_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
            out_last_next = bus.input_axis_tlast[grant_q];
            out_user_next = bus.input_axis_tuser[grant_q];
         end
      end

      case (state)
         IDLE: begin
            if (arb_hit) begin
               grant_next = arb_sel;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (accept && bus.input_axis_tlast[grant_q]) begin
               last_grant_next = grant_q;
               state_next      = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant_q    <= '0;
         last_grant <= IDX_WIDTH'(PORTS - 1);
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_user   <= 1'b0;
      end else begin
         state      <= state_next;
         grant_q    <= grant_next;
         last_grant <= last_grant_next;
         out_data   <= out_data_next;
         out_valid  <= out_valid_next;
         out_last   <= out_last_next;
         out_user   <= out_user_next;
      end
   end

   // grant_valid is the FSM state itself, so it doubles as the state observation point.
   assign grant_valid            = (state == BUSY);
   assign grant_index            = grant_q;
   assign bus.input_axis_tready  = ready;
   assign bus.output_axis_tdata  = out_data;
   assign bus.output_axis_tvalid = out_valid;
   assign bus.output_axis_tlast  = out_last;
   assign bus.output_axis_tuser  = out_user;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: per-port frame sources, an output scoreboard
// and cycle-exact checks of grant, ready and output timing.
module tb_axis_frame_arbiter;
   localparam int P  = 4;
   localparam int DW = 8;
   localparam int IW = $clog2(P);

   logic          clk = 1'b0;
   logic          rst;
   logic          grant_valid;
   logic [IW-1:0] grant_index;

   axis_frame_arbiter_if #(.PORTS(P), .DATA_WIDTH(DW)) bus ();

   axis_frame_arbiter #(.PORTS(P), .DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .grant_valid (grant_valid),
      .grant_index (grant_index)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Beat format {tuser, tlast, tdata}.
   logic [DW+1:0] exp_q[$];
   logic [DW+1:0] src_q[P][$];
   logic [P-1:0]  hold = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic queue_frame(input int p, input int n, input logic [DW-1:0] base, input logic user);
      logic          lst;
      logic [DW+1:0] beat;
      for (int i = 0; i < n; i++) begin
         lst  = (i == n - 1);
         beat = {user & lst, lst, base + DW'(i)};
         src_q[p].push_back(beat);
         exp_q.push_back(beat);
      end
   endtask

   function automatic int src_pending();
      int s = 0;
      for (int p = 0; p < P; p++) s += src_q[p].size();
      return s;
   endfunction

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || src_pending() != 0) && n < 60) begin
         tick();
         n++;
      end
      check(tag, exp_q.size(), 0);
      repeat (2) tick();
   endtask

   // Sources: handshakes are sampled mid-cycle, sources advance just after the edge.
   initial begin
      logic [P-1:0] src_fire;
      bus.input_axis_tvalid = '0;
      bus.input_axis_tdata  = '0;
      bus.input_axis_tlast  = '0;
      bus.input_axis_tuser  = '0;
      forever begin
         @(negedge clk);
         src_fire = bus.input_axis_tvalid & bus.input_axis_tready;
         @(posedge clk);
         #2;
         for (int p = 0; p < P; p++) begin
            if (src_fire[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
            if (!hold[p] && src_q[p].size() != 0) begin
               bus.input_axis_tvalid[p] = 1'b1;
               {bus.input_axis_tuser[p], bus.input_axis_tlast[p], bus.input_axis_tdata[p*DW +: DW]} = src_q[p][0];
            end else begin
               bus.input_axis_tvalid[p]       = 1'b0;
               bus.input_axis_tuser[p]        = 1'b0;
               bus.input_axis_tlast[p]        = 1'b0;
               bus.input_axis_tdata[p*DW +: DW] = '0;
            end
         end
      end
   end

   // Scoreboard: every accepted output beat must be the next expected one.
   always @(negedge clk) begin
      if (!rst && bus.output_axis_tvalid && bus.output_axis_tready) begin
         check("sb_has_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0)
            check("sb_beat", {bus.output_axis_tuser, bus.output_axis_tlast, bus.output_axis_tdata}, exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog expired observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [16:0]   pat;
      logic [16:0]   exp_pat;
      logic          found;
      logic          seen_rdy0;
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic [3:0]    bp_pat;

      rst = 1'b1;
      bus.output_axis_tready = 1'b1;
      repeat (2) tick();

      // Reset values
      check("rst_out_valid", bus.output_axis_tvalid, 0);
      check("rst_out_data", bus.output_axis_tdata, 0);
      check("rst_out_last", bus.output_axis_tlast, 0);
      check("rst_out_user", bus.output_axis_tuser, 0);
      check("rst_grant_valid", grant_valid, 0);
      check("rst_grant_index", grant_index, 0);
      check("rst_ready", bus.input_axis_tready, 0);

      // Round-robin: all ports hold 2-beat frames from reset; order 0,1,2,3,0
      queue_frame(0, 2, 8'h00, 1'b0);
      queue_frame(1, 2, 8'h10, 1'b0);
      queue_frame(2, 2, 8'h20, 1'b0);
      queue_frame(3, 2, 8'h30, 1'b0);
      queue_frame(0, 2, 8'h08, 1'b0);
      tick();
      @(negedge clk);
      check("rst_ready_blocked", bus.input_axis_tready, 0);
      tick();
      rst = 1'b0;
      exp_pat = '0;
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         pat[k]     = bus.output_axis_tvalid;
         exp_pat[k] = (k >= 2) && (((k - 2) % 3) != 2);
         if (k == 1) check("rr_first_grant", grant_index, 0);
      end
      check("rr_valid_pattern", pat, exp_pat);
      wait_drain("rr_drain");

      // Single port: port 2 sends A0,A1,A2
      queue_frame(2, 3, 8'hA0, 1'b0);
      @(negedge clk);
      check("sp_idle_gv", grant_valid, 0);
      @(negedge clk);
      check("sp_grant_valid", grant_valid, 1);
      check("sp_grant_index", grant_index, 2);
      check("sp_ready", bus.input_axis_tready, 4'b0100);
      check("sp_no_out_yet", bus.output_axis_tvalid, 0);
      @(negedge clk);
      check("sp_a0_valid", bus.output_axis_tvalid, 1);
      check("sp_a0_data", bus.output_axis_tdata, 8'hA0);
      @(negedge clk);
      check("sp_a1_data", bus.output_axis_tdata, 8'hA1);
      check("sp_a1_grant", grant_index, 2);
      @(negedge clk);
      check("sp_a2_data", bus.output_axis_tdata, 8'hA2);
      check("sp_a2_last", bus.output_axis_tlast, 1);
      check("sp_gv_fall", grant_valid, 0);
      @(negedge clk);
      check("sp_bubble", bus.output_axis_tvalid, 0);
      wait_drain("sp_drain");

      // No interleave: port 1 stalls mid-frame while port 0 requests
      queue_frame(1, 4, 8'hB0, 1'b0);
      tick();
      tick();
      hold[1] = 1'b1;
      queue_frame(0, 2, 8'hC0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("ni_ready0_hold", bus.input_axis_tready[0], 0);
         check("ni_grant_held", grant_index, 1);
      end
      tick();
      hold[1]   = 1'b0;
      found     = 1'b0;
      seen_rdy0 = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         seen_rdy0 = seen_rdy0 | bus.input_axis_tready[0];
         if (bus.output_axis_tvalid && bus.output_axis_tlast) begin
            found = 1'b1;
            check("ni_tlast_data", bus.output_axis_tdata, 8'hB3);
         end
      end
      check("ni_p1_tlast_seen", found, 1);
      check("ni_ready0_low", seen_rdy0, 0);
      wait_drain("ni_drain");

      // Backpressure: output tready 1,0,0,1 repeating during a 4-beat frame
      bp_pat     = 4'b1001;
      prev_stall = 1'b0;
      prev_data  = '0;
      queue_frame(1, 4, 8'h40, 1'b0);
      for (int k = 0; k < 12; k++) begin
         bus.output_axis_tready = bp_pat[k % 4];
         @(negedge clk);
         if (prev_stall) begin
            check("bp_hold_valid", bus.output_axis_tvalid, 1);
            check("bp_hold_data", bus.output_axis_tdata, prev_data);
         end
         if (grant_valid)
            check("bp_ready_rule", bus.input_axis_tready[1],
                  32'(!(bus.output_axis_tvalid && !bus.output_axis_tready)));
         prev_stall = bus.output_axis_tvalid && !bus.output_axis_tready;
         prev_data  = bus.output_axis_tdata;
         tick();
      end
      bus.output_axis_tready = 1'b1;
      wait_drain("bp_drain");

      // tuser pass-through on the tlast beat of port 3
      queue_frame(3, 3, 8'hD0, 1'b1);
      wait_drain("tu_drain");

      // Async reset mid-frame; port 1 served last so a stale pointer would pick port 2
      queue_frame(1, 2, 8'hE0, 1'b0);
      wait_drain("rm_pre_drain");
      queue_frame(2, 4, 8'h70, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (bus.output_axis_tvalid && bus.output_axis_tdata == 8'h71) found = 1'b1;
      end
      check("rm_reached_beat2", found, 1);
      #1;
      rst = 1'b1;
      #1;
      check("rm_out_valid", bus.output_axis_tvalid, 0);
      check("rm_grant_valid", grant_valid, 0);
      check("rm_ready", bus.input_axis_tready, 0);
      tick();
      exp_q.delete();
      for (int p = 0; p < P; p++) src_q[p].delete();
      tick();
      queue_frame(0, 2, 8'h80, 1'b0);
      queue_frame(2, 2, 8'h90, 1'b0);
      tick();
      rst   = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (grant_valid) begin
            found = 1'b1;
            check("rm_first_grant", grant_index, 0);
         end
      end
      check("rm_grant_seen", found, 1);
      wait_drain("rm_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
